// File: rtl/field_pkg.sv
// Shared types and defaults for the field RAM arbiter and its read-tag pipeline.
package field_pkg;

    localparam int FIELD_ADDR_W = 11;
    localparam int FIELD_DATA_W = 64;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_DISP = 2'd1,
        REQ_NFI  = 2'd2,
        REQ_EDIT = 2'd3
    } req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_tag_t;

    // Width of a saturating counter that must be able to hold max_val.
    function automatic int count_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Delays the originator tag of each accepted read until its RAM data is on the bus.
module rd_tag_pipe
    import field_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    in_valid,
    input  req_id_t in_id,
    output logic    disp_rvalid,
    output logic    nfi_rvalid,
    output logic    edit_rvalid,
    output logic    edit_pending
);

    rd_tag_t stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= '{valid: in_valid, id: in_id};
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    always_comb begin
        disp_rvalid  = stage[DEPTH-1].valid && (stage[DEPTH-1].id == REQ_DISP);
        nfi_rvalid   = stage[DEPTH-1].valid && (stage[DEPTH-1].id == REQ_NFI);
        edit_rvalid  = stage[DEPTH-1].valid && (stage[DEPTH-1].id == REQ_EDIT);
        edit_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (stage[i].valid && (stage[i].id == REQ_EDIT)) begin
                edit_pending = 1'b1;
            end
        end
    end

endmodule

// File: rtl/field_mem_arbiter.sv
// Arbitrates the single-port field RAM between display scan-out, the next-field engine
// and the cell editor, and tells the engine when a new generation may start.
module field_mem_arbiter
    import field_pkg::*;
#(
    parameter int ADDR_W        = FIELD_ADDR_W,
    parameter int DATA_W        = FIELD_DATA_W,
    parameter int RD_LAT        = 1,
    parameter int EDIT_MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_disp_valid,
    input  logic [ADDR_W-1:0] i_disp_addr,
    output logic              o_disp_ready,
    output logic              o_disp_rvalid,
    input  logic              i_nfi_valid,
    input  logic              i_nfi_we,
    input  logic              i_nfi_lock,
    input  logic [ADDR_W-1:0] i_nfi_addr,
    input  logic [DATA_W-1:0] i_nfi_wdata,
    output logic              o_nfi_ready,
    output logic              o_nfi_rvalid,
    input  logic              i_edit_valid,
    input  logic              i_edit_we,
    input  logic [ADDR_W-1:0] i_edit_addr,
    input  logic [DATA_W-1:0] i_edit_wdata,
    output logic              o_edit_ready,
    output logic              o_edit_rvalid,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_nfi_allowed,
    output logic              o_edit_starved
);

    localparam int WAIT_W = count_width(EDIT_MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(EDIT_MAX_WAIT);

    logic              disp_go;
    logic              nfi_go;
    logic              edit_go;
    logic              any_go;
    req_id_t           win_id;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    req_id_t           rr_ptr;
    logic              lock_active;
    req_id_t           cmd_id;
    logic [WAIT_W-1:0] edit_wait;
    logic              edit_rd_pending;
    logic              edit_in_flight;

    // DISP always wins; a held lock shuts EDIT out; otherwise rr_ptr breaks NFI/EDIT ties.
    // Grants are suppressed while reset is asserted so every output reads 0 in reset.
    always_comb begin
        disp_go = rst_n && i_disp_valid;
        nfi_go  = rst_n && !i_disp_valid && i_nfi_valid &&
                  (lock_active || !i_edit_valid || (rr_ptr == REQ_NFI));
        edit_go = rst_n && !i_disp_valid && !lock_active && i_edit_valid &&
                  (!i_nfi_valid || (rr_ptr == REQ_EDIT));
        any_go  = disp_go || nfi_go || edit_go;

        win_id    = REQ_NONE;
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        if (disp_go) begin
            win_id   = REQ_DISP;
            win_addr = i_disp_addr;
        end else if (nfi_go) begin
            win_id    = REQ_NFI;
            win_we    = i_nfi_we;
            win_addr  = i_nfi_addr;
            win_wdata = i_nfi_wdata;
        end else if (edit_go) begin
            win_id    = REQ_EDIT;
            win_we    = i_edit_we;
            win_addr  = i_edit_addr;
            win_wdata = i_edit_wdata;
        end
    end

    assign o_disp_ready = disp_go;
    assign o_nfi_ready  = nfi_go;
    assign o_edit_ready = edit_go;
    assign o_rdata      = i_mem_rdata;

    assign edit_in_flight = (o_mem_en && (cmd_id == REQ_EDIT)) || edit_rd_pending;

    // Command register plus arbitration state; a DISP grant leaves lock and rr untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_mem_en      <= 1'b0;
            o_mem_we      <= 1'b0;
            o_mem_addr    <= '0;
            o_mem_wdata   <= '0;
            cmd_id        <= REQ_NONE;
            rr_ptr        <= REQ_NFI;
            lock_active   <= 1'b0;
            edit_wait     <= '0;
            o_nfi_allowed <= 1'b0;
        end else begin
            o_mem_en <= any_go;
            if (any_go) begin
                o_mem_we    <= win_we;
                o_mem_addr  <= win_addr;
                o_mem_wdata <= win_wdata;
                cmd_id      <= win_id;
            end

            if (nfi_go) begin
                lock_active <= i_nfi_lock;
                rr_ptr      <= REQ_EDIT;
            end else if (edit_go) begin
                rr_ptr <= REQ_NFI;
            end

            if (!i_edit_valid || edit_go) begin
                edit_wait <= '0;
            end else if (edit_wait != WAIT_MAX) begin
                edit_wait <= edit_wait + 1'b1;
            end

            o_nfi_allowed <= !i_edit_valid && !edit_in_flight;
        end
    end

    assign o_edit_starved = (edit_wait == WAIT_MAX);

    rd_tag_pipe #(
        .DEPTH(RD_LAT + 1)
    ) u_rd_tag_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (any_go && !win_we),
        .in_id       (win_id),
        .disp_rvalid (o_disp_rvalid),
        .nfi_rvalid  (o_nfi_rvalid),
        .edit_rvalid (o_edit_rvalid),
        .edit_pending(edit_rd_pending)
    );

endmodule

// File: tb/tb_field_mem_arbiter.sv
// Directed bench for field_mem_arbiter with a behavioural one-cycle-latency field RAM.
module tb_field_mem_arbiter;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 64;

    logic              clk;
    logic              rst_n;
    logic              i_disp_valid;
    logic [ADDR_W-1:0] i_disp_addr;
    logic              o_disp_ready;
    logic              o_disp_rvalid;
    logic              i_nfi_valid;
    logic              i_nfi_we;
    logic              i_nfi_lock;
    logic [ADDR_W-1:0] i_nfi_addr;
    logic [DATA_W-1:0] i_nfi_wdata;
    logic              o_nfi_ready;
    logic              o_nfi_rvalid;
    logic              i_edit_valid;
    logic              i_edit_we;
    logic [ADDR_W-1:0] i_edit_addr;
    logic [DATA_W-1:0] i_edit_wdata;
    logic              o_edit_ready;
    logic              o_edit_rvalid;
    logic [DATA_W-1:0] o_rdata;
    logic              o_mem_en;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              o_nfi_allowed;
    logic              o_edit_starved;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] DATA_A = 64'h1111_2222_3333_4444;
    localparam logic [63:0] DATA_B = 64'h5555_6666_7777_8888;
    localparam logic [63:0] DATA_C = 64'hC0C0_0000_0000_0000;
    localparam logic [63:0] DATA_E = 64'hEEEE_0000_DDDD_0000;

    field_mem_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_disp_valid  (i_disp_valid),
        .i_disp_addr   (i_disp_addr),
        .o_disp_ready  (o_disp_ready),
        .o_disp_rvalid (o_disp_rvalid),
        .i_nfi_valid   (i_nfi_valid),
        .i_nfi_we      (i_nfi_we),
        .i_nfi_lock    (i_nfi_lock),
        .i_nfi_addr    (i_nfi_addr),
        .i_nfi_wdata   (i_nfi_wdata),
        .o_nfi_ready   (o_nfi_ready),
        .o_nfi_rvalid  (o_nfi_rvalid),
        .i_edit_valid  (i_edit_valid),
        .i_edit_we     (i_edit_we),
        .i_edit_addr   (i_edit_addr),
        .i_edit_wdata  (i_edit_wdata),
        .o_edit_ready  (o_edit_ready),
        .o_edit_rvalid (o_edit_rvalid),
        .o_rdata       (o_rdata),
        .o_mem_en      (o_mem_en),
        .o_mem_we      (o_mem_we),
        .o_mem_addr    (o_mem_addr),
        .o_mem_wdata   (o_mem_wdata),
        .i_mem_rdata   (i_mem_rdata),
        .o_nfi_allowed (o_nfi_allowed),
        .o_edit_starved(o_edit_starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unwritten words read back as a recognisable function of their address.
    function automatic logic [63:0] pat(input logic [ADDR_W-1:0] a);
        return 64'hF00D_0000_0000_0000 | {53'b0, a};
    endfunction

    logic [63:0] ram     [2048];
    bit          written [2048];

    always @(posedge clk) begin
        if (o_mem_en) begin
            if (o_mem_we) begin
                ram[o_mem_addr]     <= o_mem_wdata;
                written[o_mem_addr] <= 1'b1;
            end else begin
                i_mem_rdata <= written[o_mem_addr] ? ram[o_mem_addr] : pat(o_mem_addr);
            end
        end
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, then return at the falling edge.
    task automatic apply_stimulus(
        input logic dv, input logic [ADDR_W-1:0] da,
        input logic nv, input logic nwe, input logic nlk, input logic [ADDR_W-1:0] na,
        input logic [DATA_W-1:0] nwd,
        input logic ev, input logic ewe, input logic [ADDR_W-1:0] ea, input logic [DATA_W-1:0] ewd);
        @(posedge clk);
        #1;
        i_disp_valid = dv;  i_disp_addr = da;
        i_nfi_valid  = nv;  i_nfi_we = nwe; i_nfi_lock = nlk; i_nfi_addr = na; i_nfi_wdata = nwd;
        i_edit_valid = ev;  i_edit_we = ewe; i_edit_addr = ea; i_edit_wdata = ewd;
        @(negedge clk);
    endtask

    task automatic idle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] lock_seq;
        logic [ADDR_W-1:0] a;

        rst_n = 1'b0;
        i_disp_valid = 0; i_disp_addr = 0;
        i_nfi_valid = 0; i_nfi_we = 0; i_nfi_lock = 0; i_nfi_addr = 0; i_nfi_wdata = 0;
        i_edit_valid = 0; i_edit_we = 0; i_edit_addr = 0; i_edit_wdata = 0;
        repeat (2) @(negedge clk);
        check_output("rst_mem_en", o_mem_en, 0);
        check_output("rst_allowed", o_nfi_allowed, 0);
        check_output("rst_starved", o_edit_starved, 0);
        check_output("rst_rvalids", {o_disp_rvalid, o_nfi_rvalid, o_edit_rvalid}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_output("release_allowed_lo", o_nfi_allowed, 0);
        idle();
        check_output("release_allowed_hi", o_nfi_allowed, 1);

        $display("[TB] DISP priority");
        apply_stimulus(1, 10, 1, 0, 0, 20, 0, 1, 0, 30, 0);
        check_output("t1_disp_ready", o_disp_ready, 1);
        check_output("t1_other_ready", {o_nfi_ready, o_edit_ready}, 0);
        idle();
        check_output("t1_mem_en", o_mem_en, 1);
        check_output("t1_mem_addr", o_mem_addr, 10);
        check_output("t1_mem_we", o_mem_we, 0);
        check_output("t1_allowed", o_nfi_allowed, 0);
        idle();
        check_output("t1_disp_rvalid", o_disp_rvalid, 1);
        check_output("t1_rdata", o_rdata, pat(10));
        check_output("t1_other_rvalid", {o_nfi_rvalid, o_edit_rvalid}, 0);
        idle();
        check_output("t1_rvalid_width", o_disp_rvalid, 0);
        check_output("t1_mem_idle", o_mem_en, 0);

        $display("[TB] NFI/EDIT round robin");
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(0, 0, 1, 1, 0, 100, DATA_A, 1, 1, 200, DATA_B);
            check_output($sformatf("t2_nfi_ready%0d", i), o_nfi_ready, 64'(i % 2 == 0));
            check_output($sformatf("t2_edit_ready%0d", i), o_edit_ready, 64'(i % 2 == 1));
            if (i > 0) check_output($sformatf("t2_mem_addr%0d", i), o_mem_addr, (i % 2 == 1) ? 100 : 200);
        end
        idle();
        check_output("t2_last_addr", o_mem_addr, 200);
        check_output("t2_last_wdata", o_mem_wdata, DATA_B);
        check_output("t2_last_we", o_mem_we, 1);
        idle();
        check_output("t2_no_write_rvalid", {o_nfi_rvalid, o_edit_rvalid}, 0);

        $display("[TB] NFI lock");
        lock_seq = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            a = ADDR_W'(300 + i);
            apply_stimulus(0, 0, 1, 1, lock_seq[i], a, DATA_C | 64'(i), 1, 1, 400, DATA_E);
            check_output($sformatf("t3_nfi_ready%0d", i), o_nfi_ready, 1);
            check_output($sformatf("t3_edit_ready%0d", i), o_edit_ready, 0);
        end
        apply_stimulus(0, 0, 1, 1, 0, 304, DATA_C | 64'd4, 1, 1, 400, DATA_E);
        check_output("t3_edit_after_unlock", o_edit_ready, 1);
        check_output("t3_nfi_after_unlock", o_nfi_ready, 0);
        apply_stimulus(0, 0, 1, 1, 0, 304, DATA_C | 64'd4, 0, 0, 0, 0);
        check_output("t3_nfi_regrant", o_nfi_ready, 1);
        check_output("t3_edit_cmd_addr", o_mem_addr, 400);
        check_output("t3_edit_cmd_wdata", o_mem_wdata, DATA_E);
        idle();
        check_output("t3_nfi_cmd_addr", o_mem_addr, 304);

        $display("[TB] read burst");
        for (int c = 0; c < 10; c++) begin
            if (c < 4) apply_stimulus(0, 0, 1, 0, 0, ADDR_W'(c), 0, 0, 0, 0, 0);
            else if (c == 4) apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 5, 0);
            else if (c == 5) apply_stimulus(0, 0, 1, 0, 0, 100, 0, 0, 0, 0, 0);
            else idle();
            check_output($sformatf("t4_nfi_ready%0d", c), o_nfi_ready, 64'(c < 4 || c == 5));
            check_output($sformatf("t4_edit_ready%0d", c), o_edit_ready, 64'(c == 4));
            check_output($sformatf("t4_nfi_rvalid%0d", c), o_nfi_rvalid, 64'((c >= 2 && c <= 5) || c == 7));
            check_output($sformatf("t4_edit_rvalid%0d", c), o_edit_rvalid, 64'(c == 6));
            if (c >= 2 && c <= 5) check_output($sformatf("t4_rdata%0d", c), o_rdata, pat(ADDR_W'(c - 2)));
            if (c == 6) check_output("t4_rdata_edit", o_rdata, pat(5));
            if (c == 7) check_output("t4_rdata_written", o_rdata, DATA_A);
        end

        $display("[TB] EDIT starvation");
        for (int k = 0; k < 258; k++) begin
            apply_stimulus(1, 7, 0, 0, 0, 0, 0, 1, 1, 500, 64'h5);
            if (k % 64 == 0) check_output($sformatf("t5_edit_blocked%0d", k), o_edit_ready, 0);
            if (k == 1 || k == 200) check_output($sformatf("t5_allowed%0d", k), o_nfi_allowed, 0);
            if (k == 254) check_output("t5_starved_254", o_edit_starved, 0);
            if (k == 255) check_output("t5_starved_255", o_edit_starved, 1);
            if (k == 257) check_output("t5_starved_sat", o_edit_starved, 1);
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 500, 64'h5);
        check_output("t5_edit_accept", o_edit_ready, 1);
        check_output("t5_starved_at_accept", o_edit_starved, 1);
        idle();
        check_output("t5_starved_cleared", o_edit_starved, 0);
        check_output("t5_edit_cmd", {o_mem_en, o_mem_we, 5'b0, o_mem_addr}, {2'b11, 5'b0, 11'd500});
        check_output("t5_allowed_cmd", o_nfi_allowed, 0);
        idle();
        check_output("t5_allowed_inflight", o_nfi_allowed, 0);
        idle();
        check_output("t5_allowed_back", o_nfi_allowed, 1);

        $display("[TB] reset mid-read");
        apply_stimulus(0, 0, 1, 0, 0, 2, 0, 0, 0, 0, 0);
        check_output("t6_accept", o_nfi_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        i_nfi_valid = 1'b0;
        @(negedge clk);
        check_output("t6_rst_mem_en", o_mem_en, 0);
        check_output("t6_rst_mem_addr", o_mem_addr, 0);
        check_output("t6_rst_mem_wdata", o_mem_wdata, 0);
        check_output("t6_rst_ctrl", {o_mem_we, o_nfi_allowed, o_edit_starved, o_disp_ready, o_nfi_ready, o_edit_ready}, 0);
        check_output("t6_rst_rvalid", {o_disp_rvalid, o_nfi_rvalid, o_edit_rvalid}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_output("t6_no_rvalid_release", o_nfi_rvalid, 0);
        apply_stimulus(0, 0, 1, 0, 0, 40, 0, 1, 0, 41, 0);
        check_output("t6_rr_nfi_first", o_nfi_ready, 1);
        check_output("t6_rr_edit_wait", o_edit_ready, 0);
        check_output("t6_allowed_back", o_nfi_allowed, 1);
        check_output("t6_no_rvalid_late", o_nfi_rvalid, 0);
        idle();
        check_output("t6_cmd_addr", o_mem_addr, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
